smg_rx_decoder: RTL and testbench
=================================

# smg_rx_decoder

Receive-side decoder for the 74HC595-style serial seven-segment link (ds_data / ds_shcp / ds_stcp). It oversamples the three link wires in the system clock domain and shifts in 16-bit frames. On each storage-latch strobe it decodes the frame back into digit index, hex value and decimal point. It sits on the far side of the display serializer: as a bench-side checker for the display driver, or as the input stage of a slave display board.

## Interface
- SEG_ACTIVE_LOW, 1: 1 = segment byte is active-low (common anode); 0 = the segment byte is inverted before decoding.
- SEL_ACTIVE_LOW, 1: 1 = the selected digit is the single 0 bit in the select byte; 0 = it is the single 1 bit.
- clk  in  1  system clock.
- rst  in  1  reset; the reset is synchronous and active-high.
- ds_data  in  1  serial data, asynchronous to clk.
- ds_shcp  in  1  shift clock; data is captured on its rising edge.
- ds_stcp  in  1  storage latch; a frame is latched on its rising edge.
- smg_no  out  3  index of the selected digit, 0..7.
- smg_data  out  4  decoded hex value 0..F.
- smg_dp  out  1  decimal point on.
- smg_blank  out  1  all seven segments off.
- smg_valid  out  1  one-cycle pulse per latch strobe.
- frame_err  out  1  qualifies smg_valid; high means the frame is bad.
- seg_raw  out  8  last latched segment byte, unmodified.
- sel_raw  out  8  last latched select byte, unmodified.
- frame_cnt  out  8  count of latched frames; wraps at 255 to 0.

## Operation
- **Input synchronizer.** Each input passes through 2 synchronizing flops (s1, s2) plus a history flop (s3).
  - Rise of shcp = shcp_s2 & ~shcp_s3. Rise of stcp = stcp_s2 & ~stcp_s3.
  - ds_data is sampled from data_s2 in the cycle a shcp rise is detected.
- **Shift register.** 16 bits. On a shcp rise: sr <= {sr[14:0], data_s2}. The first bit shifted in is the MSB.
- **Frame format after 16 shifts.** sr[15:8] = segment byte {dp,g,f,e,d,c,b,a}. sr[7:0] = select byte.
- **Bit counter.** 5-bit counter of shifts since the last latch. It saturates at 31. It clears on a latch.
- **Segment decode.** Take the 7 low bits of the segment byte after active-low normalization (segment on = 0):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E.
  - 7F means blank.
  - Any other pattern is an error.
  - smg_dp = segment-on state of bit 7.
- **Select decode.** Exactly one active bit is required. smg_no = position of that bit. Zero or more than one active bit is an error.
- **On a stcp rise:**
  - Latch seg_raw and sel_raw.
  - Increment frame_cnt.
  - Pulse smg_valid.
  - Set frame_err = (bit count != 16) | select error | segment error.
- **Output update by frame type:**
  - Good, non-blank frame: update smg_no, smg_data and smg_dp; smg_blank = 0.
  - Good blank frame: update smg_no and smg_dp; set smg_blank = 1; smg_data holds.
  - Error frame: smg_no, smg_data, smg_dp and smg_blank all hold. seg_raw and sel_raw still update.
- **Simultaneous shcp and stcp rise in the same cycle** (595 semantics):
  - The latch captures sr before this shift.
  - The new bit becomes bit 1 of the next frame, so the bit counter goes to 1, not 0.
- **More than 16 shifts before a latch.** The latch takes the last 16 bits shifted in. frame_err = 1.
- **Reset.**
  - All outputs reset to 0: smg_valid, frame_err, smg_no, smg_data, smg_dp, smg_blank, seg_raw, sel_raw, frame_cnt.
  - sr, the bit counter and all synchronizer flops reset to 0.
  - A partial frame in progress when reset is asserted is discarded.

## Timing
- Let k be the clk edge at which s1 first samples ds_stcp high. smg_valid and all latched outputs are visible starting at edge k+2, and smg_valid is high for exactly 1 cycle.
- Decoded outputs hold until the next latch or reset.
- Link requirements:
  - shcp and stcp high time ≥ 2 clk; low time ≥ 2 clk.
  - ds_data stable from ≥ 2 clk before to ≥ 2 clk after each shcp rise.
- No backpressure. Every detected stcp rise produces one smg_valid pulse.
- A stcp rise during reset is ignored. The first rise after reset deasserts latches normally; with 0 shifts since reset, frame_err = 1.

## Test plan
- **Good frame.** Shift 16 bits A4_FB then strobe stcp → smg_valid 1 cycle; smg_no=2, smg_data=2, smg_dp=0, frame_err=0, frame_cnt=1.
- **Full value sweep.** Sweep all 16 segment codes with sel=FE, then repeat with dp bit 0 (e.g. 40_FE) → smg_data 0..F, smg_no=0; smg_dp=1 on the dp=0 frames.
- **Short frame.** Shift only 15 bits then strobe → frame_err=1; smg_no and smg_data unchanged. Next a good frame 79_F7 → no=3, data=1, err=0.
- **Bad content.** Frame FF_FD → smg_blank=1, no=1, err=0. Frame 7F_FC → err=1 (two selects active). Frame 55_7F → err=1 (unknown pattern).
- **Simultaneous edges.** Drive shcp and stcp rising together on the 17th bit → latched frame = first 16 bits; next latch after 15 more shifts → err=0.
- **Reset mid-frame and wrap.** Assert rst after 8 shifts → all outputs 0; a full frame afterwards decodes correctly. 256 frames → frame_cnt wraps to 0.

Source files
------------

// File: rtl/smg_rx_decoder.sv
// Receive-side decoder for a 74HC595-style serial seven-segment link.
// Oversamples ds_data/ds_shcp/ds_stcp in the clk domain, shifts in 16-bit
// frames and decodes each latched frame into digit index, hex value and dp.
module smg_rx_decoder #(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ds_data,
  input  logic       ds_shcp,
  input  logic       ds_stcp,
  output logic [2:0] smg_no,
  output logic [3:0] smg_data,
  output logic       smg_dp,
  output logic       smg_blank,
  output logic       smg_valid,
  output logic       frame_err,
  output logic [7:0] seg_raw,
  output logic [7:0] sel_raw,
  output logic [7:0] frame_cnt
);

  logic       data_s1_q, data_s2_q;
  logic       shcp_s1_q, shcp_s2_q, shcp_s3_q;
  logic       stcp_s1_q, stcp_s2_q, stcp_s3_q;
  logic       shcp_rise, stcp_rise;

  logic [15:0] sr_q, sr_d;
  logic [4:0]  bitcnt_q, bitcnt_d;

  logic [2:0] no_q, no_d;
  logic [3:0] data_q, data_d;
  logic       dp_q, dp_d;
  logic       blank_q, blank_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic [7:0] seg_raw_q, seg_raw_d;
  logic [7:0] sel_raw_q, sel_raw_d;
  logic [7:0] cnt_q, cnt_d;

  logic [7:0] seg_n;
  logic [7:0] sel_act;
  logic [3:0] hex_val;
  logic       seg_blank;
  logic       seg_err;
  logic [3:0] sel_ones;
  logic [2:0] sel_idx;
  logic       sel_err;

  assign shcp_rise = shcp_s2_q & ~shcp_s3_q;
  assign stcp_rise = stcp_s2_q & ~stcp_s3_q;

  // Two-flop synchronizers plus a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_s1_q <= 1'b0;
      data_s2_q <= 1'b0;
      shcp_s1_q <= 1'b0;
      shcp_s2_q <= 1'b0;
      shcp_s3_q <= 1'b0;
      stcp_s1_q <= 1'b0;
      stcp_s2_q <= 1'b0;
      stcp_s3_q <= 1'b0;
    end else begin
      data_s1_q <= ds_data;
      data_s2_q <= data_s1_q;
      shcp_s1_q <= ds_shcp;
      shcp_s2_q <= shcp_s1_q;
      shcp_s3_q <= shcp_s2_q;
      stcp_s1_q <= ds_stcp;
      stcp_s2_q <= stcp_s1_q;
      stcp_s3_q <= stcp_s2_q;
    end
  end

  // Decode the current shift register contents as a candidate frame.
  always_comb begin
    seg_n     = SEG_ACTIVE_LOW ? sr_q[15:8] : ~sr_q[15:8];
    sel_act   = SEL_ACTIVE_LOW ? ~sr_q[7:0] : sr_q[7:0];
    hex_val   = '0;
    seg_blank = 1'b0;
    seg_err   = 1'b0;
    case (seg_n[6:0])
      7'h40: hex_val = 4'h0;
      7'h79: hex_val = 4'h1;
      7'h24: hex_val = 4'h2;
      7'h30: hex_val = 4'h3;
      7'h19: hex_val = 4'h4;
      7'h12: hex_val = 4'h5;
      7'h02: hex_val = 4'h6;
      7'h78: hex_val = 4'h7;
      7'h00: hex_val = 4'h8;
      7'h10: hex_val = 4'h9;
      7'h08: hex_val = 4'hA;
      7'h03: hex_val = 4'hB;
      7'h46: hex_val = 4'hC;
      7'h21: hex_val = 4'hD;
      7'h06: hex_val = 4'hE;
      7'h0E: hex_val = 4'hF;
      7'h7F: seg_blank = 1'b1;
      default: seg_err = 1'b1;
    endcase
    sel_ones = '0;
    sel_idx  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (sel_act[i]) begin
        sel_ones = sel_ones + 4'd1;
        sel_idx  = 3'(i);
      end
    end
    sel_err = (sel_ones != 4'd1);
  end

  // Next-state for shift register, bit counter and latched outputs.
  // On a coincident shcp/stcp rise the latch sees the pre-shift sr and the
  // new bit is counted as the first bit of the following frame.
  always_comb begin
    sr_d      = sr_q;
    bitcnt_d  = bitcnt_q;
    no_d      = no_q;
    data_d    = data_q;
    dp_d      = dp_q;
    blank_d   = blank_q;
    valid_d   = 1'b0;
    err_d     = err_q;
    seg_raw_d = seg_raw_q;
    sel_raw_d = sel_raw_q;
    cnt_d     = cnt_q;
    if (shcp_rise) begin
      sr_d = {sr_q[14:0], data_s2_q};
      if (bitcnt_q != 5'd31) bitcnt_d = bitcnt_q + 5'd1;
    end
    if (stcp_rise) begin
      bitcnt_d  = shcp_rise ? 5'd1 : 5'd0;
      seg_raw_d = sr_q[15:8];
      sel_raw_d = sr_q[7:0];
      cnt_d     = cnt_q + 8'd1;
      valid_d   = 1'b1;
      err_d     = (bitcnt_q != 5'd16) | sel_err | seg_err;
      if (!((bitcnt_q != 5'd16) | sel_err | seg_err)) begin
        no_d    = sel_idx;
        dp_d    = ~seg_n[7];
        blank_d = seg_blank;
        if (!seg_blank) data_d = hex_val;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q      <= '0;
      bitcnt_q  <= '0;
      no_q      <= '0;
      data_q    <= '0;
      dp_q      <= 1'b0;
      blank_q   <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      seg_raw_q <= '0;
      sel_raw_q <= '0;
      cnt_q     <= '0;
    end else begin
      sr_q      <= sr_d;
      bitcnt_q  <= bitcnt_d;
      no_q      <= no_d;
      data_q    <= data_d;
      dp_q      <= dp_d;
      blank_q   <= blank_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      seg_raw_q <= seg_raw_d;
      sel_raw_q <= sel_raw_d;
      cnt_q     <= cnt_d;
    end
  end

  assign smg_no    = no_q;
  assign smg_data  = data_q;
  assign smg_dp    = dp_q;
  assign smg_blank = blank_q;
  assign smg_valid = valid_q;
  assign frame_err = err_q;
  assign seg_raw   = seg_raw_q;
  assign sel_raw   = sel_raw_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_smg_rx_decoder.sv
// Directed self-checking bench for smg_rx_decoder.
module tb_smg_rx_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ds_data = 1'b0;
  logic       ds_shcp = 1'b0;
  logic       ds_stcp = 1'b0;
  logic [2:0] smg_no;
  logic [3:0] smg_data;
  logic       smg_dp;
  logic       smg_blank;
  logic       smg_valid;
  logic       frame_err;
  logic [7:0] seg_raw;
  logic [7:0] sel_raw;
  logic [7:0] frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  int         pulses;
  logic       err_at_pulse;

  logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  smg_rx_decoder #(.SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .ds_data(ds_data), .ds_shcp(ds_shcp), .ds_stcp(ds_stcp),
    .smg_no(smg_no), .smg_data(smg_data), .smg_dp(smg_dp), .smg_blank(smg_blank),
    .smg_valid(smg_valid), .frame_err(frame_err), .seg_raw(seg_raw),
    .sel_raw(sel_raw), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic shift_bit(input logic b);
    ds_data = b;
    repeat (2) @(negedge clk);
    ds_shcp = 1'b1;
    repeat (2) @(negedge clk);
    ds_shcp = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Shift the top nbits of f, MSB first.
  task automatic shift_frame(input logic [15:0] f, input int nbits);
    for (int i = 15; i > 15 - nbits; i--) shift_bit(f[i]);
  endtask

  // Raise stcp (optionally together with a shcp rise carrying bit b) and
  // watch for the single smg_valid pulse within a bounded window.
  task automatic strobe(input logic with_shift, input logic b);
    if (with_shift) begin
      ds_data = b;
      repeat (2) @(negedge clk);
      ds_shcp = 1'b1;
    end
    ds_stcp = 1'b1;
    pulses = 0;
    err_at_pulse = 1'bx;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (smg_valid) begin
        pulses++;
        err_at_pulse = frame_err;
      end
    end
    ds_shcp = 1'b0;
    ds_stcp = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send(input logic [15:0] f);
    shift_frame(f, 16);
    strobe(1'b0, 1'b0);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_no", smg_no, 0);
    check("rst_data", smg_data, 0);
    check("rst_valid", smg_valid, 0);
    check("rst_err", frame_err, 0);
    check("rst_cnt", frame_cnt, 0);

    // Good frame A4_FB: digit 2 on position 2, dp off.
    send(16'hA4FB);
    check("good_pulse", pulses, 1);
    check("good_err", err_at_pulse, 0);
    check("good_no", smg_no, 2);
    check("good_data", smg_data, 2);
    check("good_dp", smg_dp, 0);
    check("good_blank", smg_blank, 0);
    check("good_cnt", frame_cnt, 1);
    check("good_segraw", seg_raw, 8'hA4);
    check("good_selraw", sel_raw, 8'hFB);

    // Sweep all codes, dp off then dp on.
    for (int dp = 0; dp < 2; dp++) begin
      for (int v = 0; v < 16; v++) begin
        send({(dp == 0) ? 1'b1 : 1'b0, codes[v], 8'hFE});
        check("sweep_err", err_at_pulse, 0);
        check("sweep_data", smg_data, v);
        check("sweep_no", smg_no, 0);
        check("sweep_dp", smg_dp, dp);
      end
    end
    check("sweep_cnt", frame_cnt, 33);

    // Short frame: 15 bits, outputs hold (last sweep left data F, no 0).
    shift_frame(16'h79F7, 15);
    strobe(1'b0, 1'b0);
    check("short_pulse", pulses, 1);
    check("short_err", err_at_pulse, 1);
    check("short_data", smg_data, 4'hF);
    check("short_no", smg_no, 0);
    send(16'h79F7);
    check("after_err", err_at_pulse, 0);
    check("after_no", smg_no, 3);
    check("after_data", smg_data, 1);
    check("after_dp", smg_dp, 1);

    // Bad content.
    send(16'hFFFD);
    check("blank_err", err_at_pulse, 0);
    check("blank_blank", smg_blank, 1);
    check("blank_no", smg_no, 1);
    check("blank_data", smg_data, 1);
    check("blank_dp", smg_dp, 0);
    send(16'h7FFC);
    check("twosel_err", err_at_pulse, 1);
    check("twosel_no", smg_no, 1);
    check("twosel_blank", smg_blank, 1);
    check("twosel_selraw", sel_raw, 8'hFC);
    send(16'h557F);
    check("badseg_err", err_at_pulse, 1);
    check("badseg_no", smg_no, 1);
    check("badseg_segraw", seg_raw, 8'h55);
    send(16'hA4FB);
    check("unblank_blank", smg_blank, 0);
    check("unblank_data", smg_data, 2);

    // Simultaneous shcp/stcp: latch sees 40_FE, the 17th bit starts 79_F7.
    shift_frame(16'h40FE, 16);
    strobe(1'b1, 1'b0);
    check("simul_pulse", pulses, 1);
    check("simul_err", err_at_pulse, 0);
    check("simul_no", smg_no, 0);
    check("simul_data", smg_data, 0);
    check("simul_segraw", seg_raw, 8'h40);
    for (int i = 14; i >= 0; i--) begin
      logic [15:0] nxt;
      nxt = 16'h79F7;
      shift_bit(nxt[i]);
    end
    strobe(1'b0, 1'b0);
    check("simul2_err", err_at_pulse, 0);
    check("simul2_no", smg_no, 3);
    check("simul2_data", smg_data, 1);

    // Reset mid-frame.
    shift_frame(16'hFFFF, 8);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_no", smg_no, 0);
    check("mrst_data", smg_data, 0);
    check("mrst_dp", smg_dp, 0);
    check("mrst_blank", smg_blank, 0);
    check("mrst_err", frame_err, 0);
    check("mrst_segraw", seg_raw, 0);
    check("mrst_selraw", sel_raw, 0);
    check("mrst_cnt", frame_cnt, 0);
    send(16'hA4FB);
    check("mrst_f_err", err_at_pulse, 0);
    check("mrst_f_no", smg_no, 2);
    check("mrst_f_data", smg_data, 2);
    check("mrst_f_cnt", frame_cnt, 1);

    // Counter wrap using empty strobes (each is an error frame but counts).
    for (int i = 0; i < 254; i++) strobe(1'b0, 1'b0);
    check("wrap_255", frame_cnt, 255);
    check("empty_err", err_at_pulse, 1);
    strobe(1'b0, 1'b0);
    check("wrap_0", frame_cnt, 0);
    check("wrap_no_hold", smg_no, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
